// File: rtl/stack_mem_port.sv
// stack_mem_port
// Stack-side access engine between the pipeline's push/pop requests and a
// 16-bit data memory. It owns an empty-descending stack pointer and splits
// each 32-bit stack word into two 16-bit memory beats. The HI half sits at
// the higher address.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   req_valid/req_op  request handshake (req_op: 0 = pop, 1 = push)
//   push_data         word to push, sampled when the request is accepted
//   req_ready         high only while idle
//   pop_valid         one-cycle pulse; pop_data holds until the next pop
//   mem_*             single-port memory with a 1-cycle synchronous read
//   sp, count         stack pointer (next free location) and stored words
//   empty, full, err  status flags; err pulses on a rejected request
module stack_mem_port #(
  parameter int AW    = 10,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_op,
  input  logic [31:0]   push_data,
  output logic          req_ready,
  output logic          pop_valid,
  output logic [31:0]   pop_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [15:0]   mem_wr_data,
  input  logic [15:0]   mem_rd_data,
  output logic [AW-1:0] sp,
  output logic [AW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_CAP
  } state_t;

  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic [AW-1:0] TWO     = AW'(2);
  localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW-1:0] count_q, count_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   lo_q, lo_d;
  logic [31:0]   pop_data_q, pop_data_d;
  logic          pop_valid_q, pop_valid_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sp_q        <= '1;
      count_q     <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    count_d     = count_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    err_d       = 1'b0;
    mem_addr    = sp_q;
    mem_wr_en   = 1'b0;
    mem_wr_data = 16'h0000;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_op) begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              wdata_d = push_data;
              state_d = PUSH_HI;
            end
          end else begin
            if (empty) begin
              err_d = 1'b1;
            end else begin
              state_d = POP_LO;
            end
          end
        end
      end
      PUSH_HI: begin
        mem_addr    = sp_q;
        mem_wr_en   = 1'b1;
        mem_wr_data = wdata_q[31:16];
        state_d     = PUSH_LO;
      end
      PUSH_LO: begin
        mem_addr    = sp_q - ONE;
        mem_wr_en   = 1'b1;
        mem_wr_data = wdata_q[15:0];
        sp_d        = sp_q - TWO;
        count_d     = count_q + ONE;
        state_d     = IDLE;
      end
      POP_LO: begin
        mem_addr = sp_q + ONE;
        state_d  = POP_HI;
      end
      POP_HI: begin
        // Read data for the LO address issued last cycle arrives now.
        mem_addr = sp_q + TWO;
        lo_d     = mem_rd_data;
        state_d  = POP_CAP;
      end
      POP_CAP: begin
        // Keep the HI address on the bus; its data is arriving now.
        mem_addr    = sp_q + TWO;
        pop_data_d  = {mem_rd_data, lo_q};
        pop_valid_d = 1'b1;
        sp_d        = sp_q + TWO;
        count_d     = count_q - ONE;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;
  assign err       = err_q;
  assign sp        = sp_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);

endmodule

// File: tb/tb_stack_mem_port.sv
// Testbench for stack_mem_port with AW = 10 and DEPTH = 4.
// Expected values come from a hand-computed vector table and from
// hand-written sequences for reset abort and back-to-back requests.
module tb_stack_mem_port;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_op;
  logic [31:0]   push_data;
  logic          req_ready;
  logic          pop_valid;
  logic [31:0]   pop_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [15:0]   mem_wr_data;
  logic [15:0]   mem_rd_data;
  logic [AW-1:0] sp;
  logic [AW-1:0] count;
  logic          empty;
  logic          full;
  logic          err;

  stack_mem_port #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .push_data(push_data),
    .req_ready(req_ready), .pop_valid(pop_valid), .pop_data(pop_data),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .sp(sp), .count(count),
    .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural 16-bit memory with a registered read.
  logic [15:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0000;
    mem_rd_data = 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        op;
    logic [31:0] data;
    logic        exp_err;
    int          exp_busy;
    logic        exp_pv;
    logic [31:0] exp_pd;
    logic [9:0]  exp_sp;
    logic [9:0]  exp_cnt;
    int          exp_nwr;
    logic [9:0]  exp_wa0;
    logic [15:0] exp_wd0;
    logic [9:0]  exp_wa1;
    logic [15:0] exp_wd1;
  } vec_t;

  vec_t vecs[13];

  // Results of the most recent transaction.
  int          t_busy;
  int          t_nwr;
  logic [9:0]  t_wa [0:1];
  logic [15:0] t_wd [0:1];
  logic        t_err;
  logic        t_pv;

  task automatic do_req(input logic op, input logic [31:0] d);
    @(negedge clk);
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    push_data = d;
    @(negedge clk);
    req_valid = 1'b0;
    t_busy = 0;
    t_nwr  = 0;
    t_wa[0] = '0; t_wa[1] = '0; t_wd[0] = '0; t_wd[1] = '0;
    while (!req_ready && t_busy < 20) begin
      if (mem_wr_en) begin
        if (t_nwr < 2) begin
          t_wa[t_nwr] = mem_addr;
          t_wd[t_nwr] = mem_wr_data;
        end
        t_nwr++;
      end
      t_busy++;
      @(negedge clk);
    end
    t_err = err;
    t_pv  = pop_valid;
  endtask

  initial begin
    // op, data, err, busy, pv, pop_data, sp, count, nwr, wa0, wd0, wa1, wd1
    vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h00000000, 10'h3FD, 10'd1, 2, 10'h3FF, 16'hDEAD, 10'h3FE, 16'hBEEF};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 3, 1'b1, 32'hDEADBEEF, 10'h3FF, 10'd0, 0, 10'h0, 16'h0, 10'h0, 16'h0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 0, 1'b0, 32'hDEADBEEF, 10'h3FF, 10'd0, 0, 10'h0, 16'h0, 10'h0, 16'h0};
    vecs[3]  = '{1'b1, 32'h11112222, 1'b0, 2, 1'b0, 32'hDEADBEEF, 10'h3FD, 10'd1, 2, 10'h3FF, 16'h1111, 10'h3FE, 16'h2222};
    vecs[4]  = '{1'b1, 32'h33334444, 1'b0, 2, 1'b0, 32'hDEADBEEF, 10'h3FB, 10'd2, 2, 10'h3FD, 16'h3333, 10'h3FC, 16'h4444};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 3, 1'b1, 32'h33334444, 10'h3FD, 10'd1, 0, 10'h0, 16'h0, 10'h0, 16'h0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 3, 1'b1, 32'h11112222, 10'h3FF, 10'd0, 0, 10'h0, 16'h0, 10'h0, 16'h0};
    vecs[7]  = '{1'b1, 32'h01011010, 1'b0, 2, 1'b0, 32'h11112222, 10'h3FD, 10'd1, 2, 10'h3FF, 16'h0101, 10'h3FE, 16'h1010};
    vecs[8]  = '{1'b1, 32'h02022020, 1'b0, 2, 1'b0, 32'h11112222, 10'h3FB, 10'd2, 2, 10'h3FD, 16'h0202, 10'h3FC, 16'h2020};
    vecs[9]  = '{1'b1, 32'h03033030, 1'b0, 2, 1'b0, 32'h11112222, 10'h3F9, 10'd3, 2, 10'h3FB, 16'h0303, 10'h3FA, 16'h3030};
    vecs[10] = '{1'b1, 32'h04044040, 1'b0, 2, 1'b0, 32'h11112222, 10'h3F7, 10'd4, 2, 10'h3F9, 16'h0404, 10'h3F8, 16'h4040};
    vecs[11] = '{1'b1, 32'h05055050, 1'b1, 0, 1'b0, 32'h11112222, 10'h3F7, 10'd4, 0, 10'h0, 16'h0, 10'h0, 16'h0};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 3, 1'b1, 32'h04044040, 10'h3F9, 10'd3, 0, 10'h0, 16'h0, 10'h0, 16'h0};

    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; push_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_sp", {22'b0, sp}, 32'h3FF);
    chk("rst_count", {22'b0, count}, 32'd0);
    chk("rst_flags", {27'b0, empty, full, req_ready, mem_wr_en, pop_valid}, 32'b10100);
    chk("rst_err", {31'b0, err}, 32'd0);

    foreach (vecs[i]) begin
      do_req(vecs[i].op, vecs[i].data);
      $display("vec %0d op=%0d data=%08h busy=%0d err=%0d pv=%0d pd=%08h sp=%03h cnt=%0d",
               i, vecs[i].op, vecs[i].data, t_busy, t_err, t_pv, pop_data, sp, count);
      chk($sformatf("v%0d_busy", i), t_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_err", i), {31'b0, t_err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_pv", i), {31'b0, t_pv}, {31'b0, vecs[i].exp_pv});
      chk($sformatf("v%0d_pd", i), pop_data, vecs[i].exp_pd);
      chk($sformatf("v%0d_sp", i), {22'b0, sp}, {22'b0, vecs[i].exp_sp});
      chk($sformatf("v%0d_cnt", i), {22'b0, count}, {22'b0, vecs[i].exp_cnt});
      chk($sformatf("v%0d_full_empty", i), {30'b0, full, empty},
          {30'b0, vecs[i].exp_cnt == 10'd4, vecs[i].exp_cnt == 10'd0});
      chk($sformatf("v%0d_nwr", i), t_nwr, vecs[i].exp_nwr);
      if (vecs[i].exp_nwr == 2) begin
        chk($sformatf("v%0d_wa0", i), {22'b0, t_wa[0]}, {22'b0, vecs[i].exp_wa0});
        chk($sformatf("v%0d_wd0", i), {16'b0, t_wd[0]}, {16'b0, vecs[i].exp_wd0});
        chk($sformatf("v%0d_wa1", i), {22'b0, t_wa[1]}, {22'b0, vecs[i].exp_wa1});
        chk($sformatf("v%0d_wd1", i), {16'b0, t_wd[1]}, {16'b0, vecs[i].exp_wd1});
      end
      // Pulses must last exactly one cycle.
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), {30'b0, err, pop_valid}, 32'd0);
    end

    // Reset during PUSH_LO of a second push aborts it.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    do_req(1'b1, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1; push_data = 32'h12345678;
    @(negedge clk);                 // PUSH_HI
    req_valid = 1'b0;
    chk("abort_in_push_hi", {31'b0, mem_wr_en}, 32'd1);
    @(negedge clk);                 // PUSH_LO
    chk("abort_in_push_lo_addr", {22'b0, mem_addr}, 32'h3FC);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("abort: ready=%0d sp=%03h cnt=%0d wr=%0d", req_ready, sp, count, mem_wr_en);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_sp", {22'b0, sp}, 32'h3FF);
    chk("abort_count", {22'b0, count}, 32'd0);
    chk("abort_wr_en", {31'b0, mem_wr_en}, 32'd0);

    // Push accepted in the same cycle that a pop completes.
    do_req(1'b1, 32'hAAAA5555);
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0;
    @(negedge clk);
    req_op = 1'b1; push_data = 32'h77778888;   // held while busy
    begin
      int n;
      n = 0;
      while (!pop_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_pop_latency", n, 3);
    end
    $display("b2b: pv=%0d pd=%08h ready=%0d", pop_valid, pop_data, req_ready);
    chk("b2b_pop_data", pop_data, 32'hAAAA5555);
    chk("b2b_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_push_hi_wr", {31'b0, mem_wr_en}, 32'd1);
    chk("b2b_push_hi_addr", {22'b0, mem_addr}, 32'h3FF);
    chk("b2b_push_hi_data", {16'b0, mem_wr_data}, 32'h7777);
    repeat (2) @(negedge clk);
    chk("b2b_final_count", {22'b0, count}, 32'd1);
    chk("b2b_final_sp", {22'b0, sp}, 32'h3FD);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
